// File: rtl/pairing_top.sv
// Data/control shell of the BLS24 pairing engine: 24-lane Fp24 working RAM, command memory and move sequencer.
// Optional build macro TOP_XOR_OP_EN enables op 11 as lane-wise XOR; otherwise op 11 is a NOP.
module pairing_top #(
    parameter int WORD_SIZE        = 16,
    parameter int RAM_ADDR_SIZE    = 6,
    parameter int CMD_MEMSIZE      = 5,
    parameter int CMD_SIZE         = 2 + 2*RAM_ADDR_SIZE,
    parameter int I_INPUTMODE_SIZE = 3,
    parameter int CMD_INSTTYPE     = CMD_MEMSIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [I_INPUTMODE_SIZE-1:0] I_INPUTMODE,
    input  logic [CMD_INSTTYPE-1:0]     I_INSTTYPE,
    input  logic [RAM_ADDR_SIZE-1:0]    I_WADDR,
    input  logic [RAM_ADDR_SIZE-1:0]    I_RADDR,
    input  logic [CMD_MEMSIZE-1:0]      I_MODE_WADDR,
    input  logic [CMD_SIZE-1:0]         I_MODE_WDATA,
    input  logic [WORD_SIZE-1:0]        I_WDATA0000,
    input  logic [WORD_SIZE-1:0]        I_WDATA0001,
    input  logic [WORD_SIZE-1:0]        I_WDATA0010,
    input  logic [WORD_SIZE-1:0]        I_WDATA0011,
    input  logic [WORD_SIZE-1:0]        I_WDATA0100,
    input  logic [WORD_SIZE-1:0]        I_WDATA0101,
    input  logic [WORD_SIZE-1:0]        I_WDATA0110,
    input  logic [WORD_SIZE-1:0]        I_WDATA0111,
    input  logic [WORD_SIZE-1:0]        I_WDATA0200,
    input  logic [WORD_SIZE-1:0]        I_WDATA0201,
    input  logic [WORD_SIZE-1:0]        I_WDATA0210,
    input  logic [WORD_SIZE-1:0]        I_WDATA0211,
    input  logic [WORD_SIZE-1:0]        I_WDATA1000,
    input  logic [WORD_SIZE-1:0]        I_WDATA1001,
    input  logic [WORD_SIZE-1:0]        I_WDATA1010,
    input  logic [WORD_SIZE-1:0]        I_WDATA1011,
    input  logic [WORD_SIZE-1:0]        I_WDATA1100,
    input  logic [WORD_SIZE-1:0]        I_WDATA1101,
    input  logic [WORD_SIZE-1:0]        I_WDATA1110,
    input  logic [WORD_SIZE-1:0]        I_WDATA1111,
    input  logic [WORD_SIZE-1:0]        I_WDATA1200,
    input  logic [WORD_SIZE-1:0]        I_WDATA1201,
    input  logic [WORD_SIZE-1:0]        I_WDATA1210,
    input  logic [WORD_SIZE-1:0]        I_WDATA1211,
    output logic [WORD_SIZE-1:0]        result0000,
    output logic [WORD_SIZE-1:0]        result0001,
    output logic [WORD_SIZE-1:0]        result0010,
    output logic [WORD_SIZE-1:0]        result0011,
    output logic [WORD_SIZE-1:0]        result0100,
    output logic [WORD_SIZE-1:0]        result0101,
    output logic [WORD_SIZE-1:0]        result0110,
    output logic [WORD_SIZE-1:0]        result0111,
    output logic [WORD_SIZE-1:0]        result0200,
    output logic [WORD_SIZE-1:0]        result0201,
    output logic [WORD_SIZE-1:0]        result0210,
    output logic [WORD_SIZE-1:0]        result0211,
    output logic [WORD_SIZE-1:0]        result1000,
    output logic [WORD_SIZE-1:0]        result1001,
    output logic [WORD_SIZE-1:0]        result1010,
    output logic [WORD_SIZE-1:0]        result1011,
    output logic [WORD_SIZE-1:0]        result1100,
    output logic [WORD_SIZE-1:0]        result1101,
    output logic [WORD_SIZE-1:0]        result1110,
    output logic [WORD_SIZE-1:0]        result1111,
    output logic [WORD_SIZE-1:0]        result1200,
    output logic [WORD_SIZE-1:0]        result1201,
    output logic [WORD_SIZE-1:0]        result1210,
    output logic [WORD_SIZE-1:0]        result1211,
    output logic                        is_busy
);

    localparam int LANES = 24;
    localparam int LW    = LANES * WORD_SIZE;

    localparam logic [I_INPUTMODE_SIZE-1:0] MODE_COORD = I_INPUTMODE_SIZE'(1);
    localparam logic [I_INPUTMODE_SIZE-1:0] MODE_CMD   = I_INPUTMODE_SIZE'(2);
    localparam logic [I_INPUTMODE_SIZE-1:0] MODE_REF   = I_INPUTMODE_SIZE'(3);
    localparam logic [I_INPUTMODE_SIZE-1:0] MODE_START = I_INPUTMODE_SIZE'(4);

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_COPY  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    localparam logic [CMD_MEMSIZE-1:0] PC_LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

    logic [LW-1:0]       ram [2**RAM_ADDR_SIZE];
    logic [CMD_SIZE-1:0] cmd_mem [2**CMD_MEMSIZE];

    state_t                   state_q, state_d;
    logic [CMD_MEMSIZE-1:0]   pc_q, pc_d;
    logic [CMD_SIZE-1:0]      cmd_p1;
    logic [LW-1:0]            res_q;
    logic [LW-1:0]            wdata_all;

    logic                     ram_we;
    logic [RAM_ADDR_SIZE-1:0] ram_waddr;
    logic [LW-1:0]            ram_wdata;
    logic                     cmd_we;

    logic [1:0]               op_p1;
    logic [RAM_ADDR_SIZE-1:0] dst_p1, src_p1;

    assign wdata_all = {I_WDATA1211, I_WDATA1210, I_WDATA1201, I_WDATA1200,
                        I_WDATA1111, I_WDATA1110, I_WDATA1101, I_WDATA1100,
                        I_WDATA1011, I_WDATA1010, I_WDATA1001, I_WDATA1000,
                        I_WDATA0211, I_WDATA0210, I_WDATA0201, I_WDATA0200,
                        I_WDATA0111, I_WDATA0110, I_WDATA0101, I_WDATA0100,
                        I_WDATA0011, I_WDATA0010, I_WDATA0001, I_WDATA0000};

    assign op_p1   = cmd_p1[CMD_SIZE-1 -: 2];
    assign dst_p1  = cmd_p1[2*RAM_ADDR_SIZE-1 -: RAM_ADDR_SIZE];
    assign src_p1  = cmd_p1[RAM_ADDR_SIZE-1:0];
    assign is_busy = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ram_we    = 1'b0;
        ram_waddr = I_WADDR;
        ram_wdata = wdata_all;
        cmd_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (I_INPUTMODE == MODE_COORD) begin
                    ram_we = 1'b1;
                end else if (I_INPUTMODE == MODE_CMD) begin
                    cmd_we = 1'b1;
                end else if (I_INPUTMODE == MODE_START) begin
                    pc_d    = I_INSTTYPE;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (op_p1 == OP_HALT) begin
                    state_d = S_IDLE;
                end else begin
                    pc_d      = pc_q + 1'b1;
                    state_d   = (pc_d == PC_LAST) ? S_IDLE : S_FETCH;
                    ram_waddr = dst_p1;
                    case (op_p1)
                        OP_COPY: begin
                            ram_we    = 1'b1;
                            ram_wdata = ram[src_p1];
                        end
                        OP_CLEAR: begin
                            ram_we    = 1'b1;
                            ram_wdata = '0;
                        end
                        default: begin
`ifdef TOP_XOR_OP_EN
                            ram_we    = 1'b1;
                            ram_wdata = ram[dst_p1] ^ ram[src_p1];
`endif
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FETCH -> EXEC boundary: command word registered for decode
    always_ff @(posedge clk) begin
        if (state_q == S_FETCH)
            cmd_p1 <= cmd_mem[pc_q];
    end

    // Memory writes are suppressed in any reset cycle so an aborted run leaves RAM untouched
    always_ff @(posedge clk) begin
        if (ram_we && !rst_n)
            ram[ram_waddr] <= ram_wdata;
        if (cmd_we && !rst_n)
            cmd_mem[I_MODE_WADDR] <= I_MODE_WDATA;
    end

    // Read port: registered, holds outside REF_RESULT, sees pre-write data on a same-edge collision
    always_ff @(posedge clk) begin
        if (rst_n)
            res_q <= '0;
        else if (I_INPUTMODE == MODE_REF)
            res_q <= ram[I_RADDR];
    end

    assign result0000 = res_q[ 0*WORD_SIZE +: WORD_SIZE];
    assign result0001 = res_q[ 1*WORD_SIZE +: WORD_SIZE];
    assign result0010 = res_q[ 2*WORD_SIZE +: WORD_SIZE];
    assign result0011 = res_q[ 3*WORD_SIZE +: WORD_SIZE];
    assign result0100 = res_q[ 4*WORD_SIZE +: WORD_SIZE];
    assign result0101 = res_q[ 5*WORD_SIZE +: WORD_SIZE];
    assign result0110 = res_q[ 6*WORD_SIZE +: WORD_SIZE];
    assign result0111 = res_q[ 7*WORD_SIZE +: WORD_SIZE];
    assign result0200 = res_q[ 8*WORD_SIZE +: WORD_SIZE];
    assign result0201 = res_q[ 9*WORD_SIZE +: WORD_SIZE];
    assign result0210 = res_q[10*WORD_SIZE +: WORD_SIZE];
    assign result0211 = res_q[11*WORD_SIZE +: WORD_SIZE];
    assign result1000 = res_q[12*WORD_SIZE +: WORD_SIZE];
    assign result1001 = res_q[13*WORD_SIZE +: WORD_SIZE];
    assign result1010 = res_q[14*WORD_SIZE +: WORD_SIZE];
    assign result1011 = res_q[15*WORD_SIZE +: WORD_SIZE];
    assign result1100 = res_q[16*WORD_SIZE +: WORD_SIZE];
    assign result1101 = res_q[17*WORD_SIZE +: WORD_SIZE];
    assign result1110 = res_q[18*WORD_SIZE +: WORD_SIZE];
    assign result1111 = res_q[19*WORD_SIZE +: WORD_SIZE];
    assign result1200 = res_q[20*WORD_SIZE +: WORD_SIZE];
    assign result1201 = res_q[21*WORD_SIZE +: WORD_SIZE];
    assign result1210 = res_q[22*WORD_SIZE +: WORD_SIZE];
    assign result1211 = res_q[23*WORD_SIZE +: WORD_SIZE];

endmodule

// File: tb/tb_pairing_top.sv
// Directed bench for pairing_top: host vector table plus hand-written program runs, reset and abort cases.
module tb_pairing_top;

    localparam int W  = 16;
    localparam int LW = 24 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    mode;
    logic [4:0]    insttype;
    logic [5:0]    waddr, raddr;
    logic [4:0]    mwaddr;
    logic [13:0]   mwdata;
    logic [LW-1:0] wd;
    wire  [LW-1:0] res_all;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int busy_cycles;

    always #5 clk = ~clk;

    pairing_top dut (
        .clk(clk), .rst_n(rst_n), .I_INPUTMODE(mode), .I_INSTTYPE(insttype),
        .I_WADDR(waddr), .I_RADDR(raddr), .I_MODE_WADDR(mwaddr), .I_MODE_WDATA(mwdata),
        .I_WDATA0000(wd[ 0*W +: W]), .I_WDATA0001(wd[ 1*W +: W]), .I_WDATA0010(wd[ 2*W +: W]),
        .I_WDATA0011(wd[ 3*W +: W]), .I_WDATA0100(wd[ 4*W +: W]), .I_WDATA0101(wd[ 5*W +: W]),
        .I_WDATA0110(wd[ 6*W +: W]), .I_WDATA0111(wd[ 7*W +: W]), .I_WDATA0200(wd[ 8*W +: W]),
        .I_WDATA0201(wd[ 9*W +: W]), .I_WDATA0210(wd[10*W +: W]), .I_WDATA0211(wd[11*W +: W]),
        .I_WDATA1000(wd[12*W +: W]), .I_WDATA1001(wd[13*W +: W]), .I_WDATA1010(wd[14*W +: W]),
        .I_WDATA1011(wd[15*W +: W]), .I_WDATA1100(wd[16*W +: W]), .I_WDATA1101(wd[17*W +: W]),
        .I_WDATA1110(wd[18*W +: W]), .I_WDATA1111(wd[19*W +: W]), .I_WDATA1200(wd[20*W +: W]),
        .I_WDATA1201(wd[21*W +: W]), .I_WDATA1210(wd[22*W +: W]), .I_WDATA1211(wd[23*W +: W]),
        .result0000(res_all[ 0*W +: W]), .result0001(res_all[ 1*W +: W]), .result0010(res_all[ 2*W +: W]),
        .result0011(res_all[ 3*W +: W]), .result0100(res_all[ 4*W +: W]), .result0101(res_all[ 5*W +: W]),
        .result0110(res_all[ 6*W +: W]), .result0111(res_all[ 7*W +: W]), .result0200(res_all[ 8*W +: W]),
        .result0201(res_all[ 9*W +: W]), .result0210(res_all[10*W +: W]), .result0211(res_all[11*W +: W]),
        .result1000(res_all[12*W +: W]), .result1001(res_all[13*W +: W]), .result1010(res_all[14*W +: W]),
        .result1011(res_all[15*W +: W]), .result1100(res_all[16*W +: W]), .result1101(res_all[17*W +: W]),
        .result1110(res_all[18*W +: W]), .result1111(res_all[19*W +: W]), .result1200(res_all[20*W +: W]),
        .result1201(res_all[21*W +: W]), .result1210(res_all[22*W +: W]), .result1211(res_all[23*W +: W]),
        .is_busy(busy)
    );

    typedef struct {
        logic [2:0]  mode;
        logic [5:0]  addr;
        logic [15:0] wbase;
        bit          winc;
        bit          chk;
        logic [15:0] ebase;
        bit          einc;
        string       name;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [LW-1:0] pat(input logic [15:0] base, input bit inc, input bit inv);
        logic [LW-1:0] p;
        logic [15:0]   v;
        p = '0;
        for (int l = 0; l < 24; l++) begin
            v = base + (inc ? 16'(l) : 16'd0);
            if (inv) v = ~v;
            p[l*W +: W] = v;
        end
        return p;
    endfunction

    function automatic logic [13:0] mkcmd(input logic [1:0] op, input logic [5:0] dst, input logic [5:0] src);
        return {op, dst, src};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (busy) busy_cycles++;
    endtask

    task automatic check_res(input string name, input logic [LW-1:0] exp);
        total++;
        if (res_all !== exp) begin
            bad++;
            for (int l = 0; l < 24; l++) begin
                if (res_all[l*W +: W] !== exp[l*W +: W]) begin
                    $display("FAIL %s lane %0d got %h expected %h", name, l, res_all[l*W +: W], exp[l*W +: W]);
                    break;
                end
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic ref_read(input string name, input logic [5:0] a, input logic [LW-1:0] exp);
        mode  = 3'd3;
        raddr = a;
        step();
        mode  = 3'd0;
        check_res(name, exp);
    endtask

    task automatic run_prog(input logic [4:0] start, output int cycles);
        int guard;
        busy_cycles = 0;
        insttype = start;
        mode     = 3'd4;
        step();
        mode  = 3'd0;
        guard = 0;
        while (busy && guard < 200) begin
            step();
            guard++;
        end
        cycles = busy_cycles;
    endtask

    logic [LW-1:0] xor_exp;
    int cyc;

    initial begin
        tbl[0] = '{3'd1, 6'd5, 16'h1000, 1'b1, 1'b0, 16'h0000, 1'b0, "wr5"};
        tbl[1] = '{3'd1, 6'd8, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0, "wr8"};
        tbl[2] = '{3'd1, 6'd9, 16'h2000, 1'b1, 1'b0, 16'h0000, 1'b0, "wr9"};
        tbl[3] = '{3'd3, 6'd5, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b1, "ref5"};
        tbl[4] = '{3'd3, 6'd8, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, "ref8"};
        tbl[5] = '{3'd5, 6'd8, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, "mode5_hold"};
        tbl[6] = '{3'd7, 6'd9, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, "mode7_hold"};
        tbl[7] = '{3'd3, 6'd9, 16'h0000, 1'b0, 1'b1, 16'h2000, 1'b1, "ref9"};
        tbl[8] = '{3'd3, 6'd8, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, "ref8_after_mode5"};
        tbl[9] = '{3'd0, 6'd5, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, "idle_hold"};

        rst_n = 1'b1; mode = 3'd0; insttype = '0; waddr = '0; raddr = '0;
        mwaddr = '0; mwdata = '0; wd = '0; busy_cycles = 0;
        step();
        step();
        check_res("reset_results", '0);
        check_int("reset_busy", int'(busy), 0);
        rst_n = 1'b0;

        for (int i = 0; i < 10; i++) begin
            mode  = tbl[i].mode;
            waddr = tbl[i].addr;
            raddr = tbl[i].addr;
            wd    = pat(tbl[i].wbase, tbl[i].winc, 1'b0);
            step();
            if (tbl[i].chk) check_res(tbl[i].name, pat(tbl[i].ebase, tbl[i].einc, 1'b0));
        end
        mode = 3'd0;

        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        check_res("reset_nonzero_results", '0);
        check_int("reset_nonzero_busy", int'(busy), 0);

        for (int i = 0; i < 32; i++) begin
            mode   = 3'd2;
            mwaddr = 5'(i);
            case (i)
                0:       mwdata = mkcmd(2'b01, 6'd7, 6'd5);
                2:       mwdata = mkcmd(2'b10, 6'd7, 6'd0);
                3:       mwdata = mkcmd(2'b11, 6'd8, 6'd5);
                5:       mwdata = mkcmd(2'b01, 6'd11, 6'd5);
                6:       mwdata = mkcmd(2'b10, 6'd9, 6'd0);
                7:       mwdata = mkcmd(2'b10, 6'd5, 6'd0);
                30:      mwdata = mkcmd(2'b01, 6'd12, 6'd5);
                31:      mwdata = mkcmd(2'b10, 6'd5, 6'd0);
                default: mwdata = mkcmd(2'b00, 6'd0, 6'd0);
            endcase
            step();
        end
        mode = 3'd0;

        run_prog(5'd0, cyc);
        check_int("copy_prog_busy", cyc, 4);
        ref_read("copy_dst7", 6'd7, pat(16'h1000, 1'b1, 1'b0));

        busy_cycles = 0;
        insttype = 5'd2;
        mode     = 3'd4;
        step();
        mode  = 3'd1;
        waddr = 6'd5;
        wd    = pat(16'hDEAD, 1'b0, 1'b0);
        step();
        mode  = 3'd3;
        raddr = 6'd5;
        step();
        check_res("ref_while_busy", pat(16'h1000, 1'b1, 1'b0));
        mode     = 3'd4;
        insttype = 5'd0;
        step();
        mode = 3'd0;
        for (int g = 0; g < 50 && busy; g++) step();
        check_int("clear_xor_prog_busy", busy_cycles, 6);
        ref_read("clear_dst7", 6'd7, '0);
`ifdef TOP_XOR_OP_EN
        xor_exp = pat(16'h1000, 1'b1, 1'b1);
`else
        xor_exp = pat(16'hFFFF, 1'b0, 1'b0);
`endif
        ref_read("xor_dst8", 6'd8, xor_exp);
        ref_read("busy_write_ignored5", 6'd5, pat(16'h1000, 1'b1, 1'b0));

        run_prog(5'd30, cyc);
        check_int("pc_end_busy", cyc, 2);
        ref_read("pc_end_copy12", 6'd12, pat(16'h1000, 1'b1, 1'b0));
        ref_read("pc_end_no_cmd31", 6'd5, pat(16'h1000, 1'b1, 1'b0));

        insttype = 5'd5;
        mode     = 3'd4;
        step();
        mode = 3'd0;
        step();
        step();
        step();
        rst_n = 1'b1;
        step();
        check_int("abort_busy", int'(busy), 0);
        rst_n = 1'b0;
        for (int g = 0; g < 6; g++) step();
        check_int("abort_stays_idle", int'(busy), 0);
        ref_read("abort_no_clear9", 6'd9, pat(16'h2000, 1'b1, 1'b0));
        ref_read("abort_first_copy11", 6'd11, pat(16'h1000, 1'b1, 1'b0));
        ref_read("abort_no_clear5", 6'd5, pat(16'h1000, 1'b1, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pairing_top.md
# pairing_top

- Top-level data and control shell of the BLS24 pairing engine.
- Holds a 24-lane Fp24 working RAM and a command memory.
- A host loads operands and a micro-program, runs the program as lane-parallel move operations, and reads any Fp24 element back onto 24 result buses.
- Lane suffix `abcd` (a∈0..1, b∈0..2, c,d∈0..1) indexes the Fp2→Fp4→Fp12→Fp24 tower coefficient.

## Interface
Parameters:
- WORD_SIZE, 16, width of one Fp lane word.
- RAM_ADDR_SIZE, 6, working-RAM address width (64 Fp24 entries).
- CMD_MEMSIZE, 5, command-memory address width (32 commands).
- CMD_SIZE, 2+2*RAM_ADDR_SIZE, command word width: {op[1:0], dst, src}.
- I_INPUTMODE_SIZE, 3; CMD_INSTTYPE, CMD_MEMSIZE.

Ports:
- Clocking and reset:
  - clk, in, 1, single clock; all state updates on the rising edge.
  - rst_n, in, 1, reset, synchronous, active-high: reset takes effect on a rising clk edge while rst_n=1.
- Control inputs:
  - I_INPUTMODE, in, 3, 0 IDLE, 1 INPUT_COORD_CORE, 2 INPUT_CMD, 3 REF_RESULT, 4 START; 5–7 act as IDLE.
  - I_INSTTYPE, in, CMD_MEMSIZE, program start address used by START.
  - I_WADDR / I_RADDR, in, RAM_ADDR_SIZE, RAM write / read address.
  - I_MODE_WADDR, in, CMD_MEMSIZE, command-memory write address.
  - I_MODE_WDATA, in, CMD_SIZE, command word.
- Data:
  - I_WDATA0000…I_WDATA1211, in, WORD_SIZE each (24 ports), write lanes.
  - result0000…result1211, out, WORD_SIZE each (24 ports), read lanes.
- Status:
  - is_busy, out, 1, program executing.

## Operation
- Storage:
  - RAM: 2^RAM_ADDR_SIZE entries × 24 lanes.
  - Command memory: 2^CMD_MEMSIZE × CMD_SIZE.
  - Neither memory is cleared by reset.
- Host modes while not busy:
  - IDLE: nothing happens.
  - INPUT_COORD_CORE: RAM[I_WADDR] ← all 24 I_WDATA lanes, lane-matched.
  - INPUT_CMD: CMD[I_MODE_WADDR] ← I_MODE_WDATA.
  - REF_RESULT: result lanes ← RAM[I_RADDR].
  - START: pc ← I_INSTTYPE, is_busy ← 1.
- Run FSM: IDLE → FETCH → EXEC → FETCH …
  - FETCH registers CMD[pc].
  - EXEC decodes op:
    - 00 HALT: go to IDLE, is_busy ← 0.
    - 01 COPY: RAM[dst] ← RAM[src].
    - 10 CLEAR: RAM[dst] ← 0.
    - 11 XOR: RAM[dst] ← RAM[dst] ^ RAM[src], lane-wise (see Configuration).
  - After a non-HALT EXEC, pc increments.
  - If pc equals 2^CMD_MEMSIZE−1 after EXEC, the run ends as if HALT.
- While busy:
  - INPUT_COORD_CORE, INPUT_CMD and START are ignored.
  - REF_RESULT is still served and reads the current RAM contents.
  - Same-cycle host read and engine write to one address returns the old data.
- COPY with dst==src leaves the contents unchanged.
- XOR with dst==src yields 0.
- Result registers hold their value outside REF_RESULT.

## Timing
- Reset values: all result lanes 0, is_busy 0, FSM IDLE, pc 0.
- A reset during a run aborts it; no further RAM write occurs.
- Writes: data sampled on the edge where the mode is active; readable via REF_RESULT from the next cycle.
- Read latency: results valid 1 cycle after the edge that samples REF_RESULT/I_RADDR.
- START:
  - is_busy rises the cycle after the START edge.
  - Each non-HALT command takes 2 cycles.
  - HALT drops is_busy 2 cycles after its FETCH begins.
  - Program of N moves + HALT: busy for 2N+2 cycles.
- START must be deasserted or left while busy; it does not retrigger until is_busy=0.

## Configuration
- TOP_XOR_OP_EN defined: op 11 performs lane-wise XOR as above.
- TOP_XOR_OP_EN undefined: op 11 is a NOP that advances pc; no RAM write.

## Test plan
- Reset while results nonzero: results all 0 and is_busy 0 one edge after rst_n=1.
- Write 0x1000+lane into addr 5, then REF_RESULT addr 5: result0000=0x1000 … result1211=0x1017 after 1 cycle.
- CMD[0]=COPY dst 7 src 5, CMD[1]=HALT; START with I_INSTTYPE=0:
  - is_busy high for 4 cycles.
  - Reading addr 7 returns 0x1000…0x1017.
- CMD[2]=CLEAR 7, CMD[3]=XOR 8←5 (addr 8 preloaded with 0xFFFF in all lanes), CMD[4]=HALT; START at 2:
  - Addr 7 reads 0.
  - Addr 8 reads ~(0x1000+lane) with TOP_XOR_OP_EN; unchanged without it.
- INPUT_COORD_CORE to addr 5 while busy: addr 5 unchanged after the run.
- Assert rst_n mid-run: is_busy 0 next cycle; commands after the abort never write RAM.
